// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source select
// encoding (numeric order equals priority) and the word-alignment helper.
// No ports; imported by pc_next_mux and pc_sequencer.
package pc_pkg;

    // Source select; a larger value always means a higher priority, so a
    // plain magnitude compare decides whether a redirect may replace another.
    typedef enum logic [2:0] {
        PC_SEQ  = 3'd0,
        PC_JUMP = 3'd1,
        PC_JR   = 3'd2,
        PC_BR   = 3'd3,
        PC_EXC  = 3'd4
    } pc_sel_e;

    // Widest PC this package supports; callers cast to their own width.
    localparam int PC_MAX_W = 64;

    // Force a target onto a 4-byte instruction boundary.
    function automatic logic [PC_MAX_W-1:0] pc_align(input logic [PC_MAX_W-1:0] t);
        return {t[PC_MAX_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select of the next-PC source.
// Ports: raw redirect requests/targets, pending redirect state and pc_plus_4 in;
//        highest new redirect (new_vld/new_sel/new_target) and overall winner (sel/target) out.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80
) (
    input  logic             exc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] rind,
    input  logic             jump,
    input  logic [WIDTH-1:0] jabs,
    input  logic             pend_valid,
    input  pc_sel_e          pend_sel,
    input  logic [WIDTH-1:0] pend_target,
    input  logic [WIDTH-1:0] pc_plus_4,
    output logic             new_vld,
    output pc_sel_e          new_sel,
    output logic [WIDTH-1:0] new_target,
    output pc_sel_e          sel,
    output logic [WIDTH-1:0] target
);

    // Highest-priority redirect requested this cycle (pending excluded).
    always_comb begin
        new_vld    = 1'b0;
        new_sel    = PC_SEQ;
        new_target = pc_plus_4;
        if (exc) begin
            new_vld    = 1'b1;
            new_sel    = PC_EXC;
            new_target = EXC_VECTOR;
        end else if (br_taken) begin
            new_vld    = 1'b1;
            new_sel    = PC_BR;
            new_target = br_target;
        end else if (jr) begin
            new_vld    = 1'b1;
            new_sel    = PC_JR;
            new_target = rind;
        end else if (jump) begin
            new_vld    = 1'b1;
            new_sel    = PC_JUMP;
            new_target = jabs;
        end
    end

    // A fresh redirect always beats the captured one; the pending entry only
    // matters when nothing new arrives.
    always_comb begin
        sel    = PC_SEQ;
        target = pc_plus_4;
        if (new_vld) begin
            sel    = new_sel;
            target = new_target;
        end else if (pend_valid) begin
            sel    = pend_sel;
            target = pend_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch PC with stall handling and a one-entry pending-redirect register.
// Ports: clk/rst, stall, redirect requests (exc, br_taken, jr, jump) with targets in;
//        pc, pc_plus_4 (zero latency), flush and misalign (combinational, acceptance cycle) out.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] rind,
    input  logic             jump,
    input  logic [WIDTH-1:0] jabs,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_4,
    output logic             flush,
    output logic             misalign
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    pc_sel_e          pend_sel_q, pend_sel_d;

    logic             new_vld;
    pc_sel_e          new_sel;
    logic [WIDTH-1:0] new_target;
    pc_sel_e          mux_sel;
    logic [WIDTH-1:0] mux_target;

    assign pc        = pc_q;
    assign pc_plus_4 = pc_q + WIDTH'(4);

    pc_next_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .exc         (exc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jr          (jr),
        .rind        (rind),
        .jump        (jump),
        .jabs        (jabs),
        .pend_valid  (pend_valid_q),
        .pend_sel    (pend_sel_q),
        .pend_target (pend_target_q),
        .pc_plus_4   (pc_plus_4),
        .new_vld     (new_vld),
        .new_sel     (new_sel),
        .new_target  (new_target),
        .sel         (mux_sel),
        .target      (mux_target)
    );

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_sel_d    = pend_sel_q;
        flush         = 1'b0;
        misalign      = 1'b0;

        // An exception ignores stall; since it is top priority in the mux it
        // shares the unstalled load path.
        if (exc || !stall) begin
            if (mux_sel != PC_SEQ) begin
                pc_d         = WIDTH'(pc_align(PC_MAX_W'(mux_target)));
                pend_valid_d = 1'b0;
                flush        = 1'b1;
                misalign     = (mux_sel != PC_EXC) && (mux_target[1:0] != 2'b00);
            end else begin
                pc_d = pc_plus_4;
            end
        end else if (new_vld && (!pend_valid_q || new_sel >= pend_sel_q)) begin
            // Stalled: keep the raw target so misalign can still be reported
            // when the redirect is finally applied.
            pend_valid_d  = 1'b1;
            pend_target_d = new_target;
            pend_sel_d    = new_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_sel_q    <= PC_SEQ;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_sel_q    <= pend_sel_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jr = 1'b0;
    logic [31:0] rind = '0;
    logic        jump = 1'b0;
    logic [31:0] jabs = '0;
    logic        exc = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        flush;
    logic        misalign;

    pc_sequencer #(
        .WIDTH      (32),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jr        (jr),
        .rind      (rind),
        .jump      (jump),
        .jabs      (jabs),
        .exc       (exc),
        .pc        (pc),
        .pc_plus_4 (pc_plus_4),
        .flush     (flush),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural PC plus an optional remembered redirect
    // with its priority rank (exc 4, branch 3, jr 2, jump 1).
    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pt;
    int          m_pr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_pv = 0;
        m_pt = 32'h0;
        m_pr = 0;
    endtask

    // Called at a falling edge: drive one cycle of inputs, check outputs
    // before the rising edge, then advance the model.
    task automatic cycle(input bit st, input bit ex, input bit bt, input logic [31:0] btt,
                         input bit j_r, input logic [31:0] ri, input bit jp, input logic [31:0] ja);
        int          nr;
        logic [31:0] nt;
        logic [31:0] nxt;
        bit          e_fl, e_mis;
        stall = st; exc = ex; br_taken = bt; br_target = btt;
        jr = j_r; rind = ri; jump = jp; jabs = ja;
        #1;
        nr = 0; nt = '0;
        if (jp)  begin nr = 1; nt = ja;  end
        if (j_r) begin nr = 2; nt = ri;  end
        if (bt)  begin nr = 3; nt = btt; end
        nxt = m_pc; e_fl = 0; e_mis = 0;
        if (ex) begin
            nxt = 32'h80; e_fl = 1; m_pv = 0;
        end else if (st) begin
            if (nr > 0 && (!m_pv || nr >= m_pr)) begin
                m_pv = 1; m_pt = nt; m_pr = nr;
            end
        end else if (nr > 0) begin
            nxt = nt - (nt % 4); e_fl = 1; e_mis = (nt % 4) != 0; m_pv = 0;
        end else if (m_pv) begin
            nxt = m_pt - (m_pt % 4); e_fl = 1; e_mis = (m_pt % 4) != 0; m_pv = 0;
        end else begin
            nxt = m_pc + 32'd4;
        end
        chk("pc", pc, m_pc);
        chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
        chk("flush", 32'(flush), 32'(e_fl));
        chk("misalign", 32'(misalign), 32'(e_mis));
        @(posedge clk);
        m_pc = nxt;
        @(negedge clk);
    endtask

    task automatic free_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse entirely between clock edges.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset and sequential flow
        free_cycle();
        free_cycle();
        pulse_reset();
        free_cycle();
        free_cycle();
        free_cycle();
        chk("seq_pc12", pc, 32'd12);

        // Simultaneous redirects: branch beats jump
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h40);
        chk("pc_40", pc, 32'h40);
        cycle(0, 0, 1, 32'h100, 0, 0, 1, 32'h200);
        chk("br_wins", pc, 32'h100);

        // Redirects during stall
        cycle(1, 0, 0, 0, 0, 0, 1, 32'h300);
        cycle(1, 0, 1, 32'h500, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 32'h600);
        free_cycle();
        chk("stall_release", pc, 32'h500);
        free_cycle();

        // Exception overrides stall and pending
        cycle(1, 0, 1, 32'h500, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk("exc_pc", pc, 32'h80);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        free_cycle();
        chk("exc_release", pc, 32'h84);

        // Misaligned target and wrap
        cycle(0, 0, 0, 0, 1, 32'h1003, 0, 0);
        chk("jr_align", pc, 32'h1000);
        free_cycle();
        cycle(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        free_cycle();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_p4", pc_plus_4, 32'h4);
        free_cycle();

        // Reset while a redirect is pending
        cycle(1, 0, 0, 0, 0, 0, 1, 32'h300);
        stall = 1'b1;
        pulse_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        free_cycle();
        chk("rst_drops_pend", pc, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 4,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 6) == 0, $urandom,
                  $urandom_range(0, 6) == 0, $urandom,
                  $urandom_range(0, 6) == 0, $urandom);
        end
        free_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
